// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter with next-PC selection (sequential, branch, jump, jr)
// and a single-entry pending slot for redirects that arrive while fetch is stalled.
//
// state | meaning
// BOOT  | out of reset, valid low; first edge moves to RUN, redirects ignored
// RUN   | valid high, no redirect pending
// HOLD  | valid high, a redirect target waits in pend_q for ready
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ready,
   input  logic [31:0] redir_pc4,
   input  logic        branch,
   input  logic [31:0] branch_off,
   input  logic        jump,
   input  logic [25:0] jump_idx,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        valid,
   output logic        misalign
);

   typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        mis_q, mis_d;
   logic        redir;
   logic [31:0] redir_tgt;

   assign pc       = pc_q;
   assign pc_plus4 = pc_q + 32'd4;
   assign valid    = (state_q != BOOT);
   assign misalign = mis_q;
   assign redir    = branch | jump | jr;

   // jr outranks jump, which outranks branch
   always_comb begin
      redir_tgt = redir_pc4 + branch_off;
      if (jr) begin
         redir_tgt = {jr_addr[31:2], 2'b00};
      end else if (jump) begin
         redir_tgt = {redir_pc4[31:28], jump_idx, 2'b00};
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      mis_d   = mis_q;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redir && ready) begin
               pc_d = redir_tgt;
            end else if (redir) begin
               pend_d  = redir_tgt;
               state_d = HOLD;
            end else if (ready) begin
               pc_d = pc_plus4;
            end
         end
         HOLD: begin
            // a fresh redirect supersedes the one already pending
            if (ready) begin
               pc_d    = redir ? redir_tgt : pend_q;
               state_d = RUN;
            end else if (redir) begin
               pend_d = redir_tgt;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
      if ((state_q != BOOT) && jr && (jr_addr[1:0] != 2'b00)) begin
         mis_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         pend_q  <= 32'h0000_0000;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of the PC/pending-redirect behaviour.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        ready;
   logic [31:0] redir_pc4;
   logic        branch;
   logic [31:0] branch_off;
   logic        jump;
   logic [25:0] jump_idx;
   logic        jr;
   logic [31:0] jr_addr;
   logic [31:0] pc, pc_plus4, pc_w, pc_plus4_w;
   logic        valid, misalign, valid_w, misalign_w;

   int checks;
   int failures;

   // model state for the RESET_PC=0 instance
   logic [31:0] m_pc;
   logic [31:0] m_pend;
   bit          m_pend_v;
   bit          m_booted;
   bit          m_mis;

   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .ready(ready), .redir_pc4(redir_pc4),
      .branch(branch), .branch_off(branch_off), .jump(jump), .jump_idx(jump_idx),
      .jr(jr), .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
      .valid(valid), .misalign(misalign)
   );

   pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst(rst), .ready(ready), .redir_pc4(redir_pc4),
      .branch(branch), .branch_off(branch_off), .jump(jump), .jump_idx(jump_idx),
      .jr(jr), .jr_addr(jr_addr), .pc(pc_w), .pc_plus4(pc_plus4_w),
      .valid(valid_w), .misalign(misalign_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc     = 32'h0;
      m_pend   = 32'h0;
      m_pend_v = 0;
      m_booted = 0;
      m_mis    = 0;
   endtask

   // One edge of the fetch contract: a transfer takes the newest redirect, else the
   // pending one, else pc+4; a stalled redirect is remembered.
   task automatic model_step();
      bit          r;
      logic [31:0] tgt;
      if (!m_booted) begin
         m_booted = 1;
         return;
      end
      r = branch || jump || jr;
      if (jr)        tgt = jr_addr & 32'hFFFF_FFFC;
      else if (jump) tgt = (redir_pc4 & 32'hF000_0000) | (32'(jump_idx) * 4);
      else           tgt = redir_pc4 + branch_off;
      if (jr && (jr_addr % 4 != 0)) m_mis = 1;
      if (ready) begin
         m_pc     = r ? tgt : (m_pend_v ? m_pend : m_pc + 32'd4);
         m_pend_v = 0;
      end else if (r) begin
         m_pend   = tgt;
         m_pend_v = 1;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redir();
      branch = 0; jump = 0; jr = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst = 1;
   endtask

   task automatic test_reset();
      clear_redir();
      ready = 1;
      redir_pc4 = 0; branch_off = 0; jump_idx = 0; jr_addr = 0;
      rst = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (pc !== 32'h0 || valid !== 1'b0 || misalign !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: pc=%h valid=%b mis=%b, expected pc=0 valid=0 mis=0", pc, valid, misalign);
      end
      rst = 1;
      cycle();
      checks++;
      if (pc !== 32'h0 || valid !== 1'b1) begin
         failures++;
         $display("FAIL boot: pc=%h valid=%b, expected pc=0 valid=1", pc, valid);
      end
      for (int i = 1; i <= 3; i++) begin
         cycle();
         checks++;
         if (pc !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4) || valid !== 1'b1) begin
            failures++;
            $display("FAIL seq_step%0d: pc=%h pc_plus4=%h valid=%b, expected pc=%h", i, pc, pc_plus4, valid, 32'(4 * i));
         end
      end
   endtask

   task automatic test_branch();
      cycle();
      checks++;
      if (pc !== 32'h10) begin
         failures++;
         $display("FAIL pre_branch: pc=%h expected 00000010", pc);
      end
      redir_pc4 = 32'h0C; branch_off = 32'hFFFF_FFF8; branch = 1;
      cycle();
      checks++;
      if (pc !== 32'h04 || pc !== m_pc) begin
         failures++;
         $display("FAIL branch_back: pc=%h expected 00000004", pc);
      end
      branch_off = 32'h40;
      cycle();
      checks++;
      if (pc !== 32'h4C) begin
         failures++;
         $display("FAIL branch_fwd: pc=%h expected 0000004c", pc);
      end
      clear_redir();
   endtask

   task automatic test_priority();
      redir_pc4 = 32'h4000_0010; jump_idx = 26'h100; jump = 1; branch = 1;
      branch_off = 32'h0000_0100;
      cycle();
      checks++;
      if (pc !== 32'h4000_0400) begin
         failures++;
         $display("FAIL jump_over_branch: pc=%h expected 40000400", pc);
      end
      jr = 1; jr_addr = 32'h0000_2000;
      cycle();
      checks++;
      if (pc !== 32'h0000_2000 || misalign !== 1'b0) begin
         failures++;
         $display("FAIL jr_over_all: pc=%h mis=%b expected 00002000 mis=0", pc, misalign);
      end
      clear_redir();
   endtask

   task automatic test_stall_redirect();
      logic [31:0] held;
      held = pc;
      ready = 0; redir_pc4 = 32'h40; branch_off = 32'h40; branch = 1;
      cycle();
      branch = 0;
      checks++;
      if (pc !== held || valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_capture: pc=%h valid=%b expected pc=%h valid=1", pc, valid, held);
      end
      for (int i = 0; i < 3; i++) cycle();
      checks++;
      if (pc !== held || valid !== 1'b1) begin
         failures++;
         $display("FAIL stall_hold: pc=%h valid=%b expected pc=%h valid=1", pc, valid, held);
      end
      ready = 1;
      cycle();
      checks++;
      if (pc !== 32'h80) begin
         failures++;
         $display("FAIL stall_release: pc=%h expected 00000080", pc);
      end
      cycle();
      checks++;
      if (pc !== 32'h84) begin
         failures++;
         $display("FAIL after_release: pc=%h expected 00000084", pc);
      end
      ready = 0; branch = 1;
      cycle();
      branch_off = 32'hC0;
      cycle();
      branch = 0;
      cycle();
      checks++;
      if (pc !== 32'h84) begin
         failures++;
         $display("FAIL stall2_hold: pc=%h expected 00000084", pc);
      end
      ready = 1;
      cycle();
      checks++;
      if (pc !== 32'h100) begin
         failures++;
         $display("FAIL newer_wins: pc=%h expected 00000100", pc);
      end
   endtask

   task automatic test_misalign();
      jr = 1; jr_addr = 32'h0000_1006; ready = 1;
      cycle();
      jr = 0;
      checks++;
      if (pc !== 32'h1004 || misalign !== 1'b1) begin
         failures++;
         $display("FAIL jr_misalign: pc=%h mis=%b expected 00001004 mis=1", pc, misalign);
      end
      redir_pc4 = 32'h200; branch_off = 32'h8; branch = 1;
      cycle();
      clear_redir();
      cycle();
      checks++;
      if (pc !== 32'h20C || misalign !== 1'b1) begin
         failures++;
         $display("FAIL mis_sticky: pc=%h mis=%b expected 0000020c mis=1", pc, misalign);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         ready      = ($urandom_range(0, 99) < 55);
         branch     = ($urandom_range(0, 99) < 25);
         jump       = ($urandom_range(0, 99) < 15);
         jr         = ($urandom_range(0, 99) < 12);
         redir_pc4  = $urandom & 32'hFFFF_FFFC;
         branch_off = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 1023)) << 2 : (32'hFFFF_FFFF - 32'($urandom_range(0, 1023))) << 2;
         jump_idx   = 26'($urandom);
         jr_addr    = $urandom;
         if (n < 300 && jr_addr[1:0] != 2'b00) jr_addr[1:0] = 2'b00;
         cycle();
         checks++;
         if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || valid !== m_booted || misalign !== m_mis) begin
            failures++;
            $display("FAIL rand_cycle%0d: pc=%h pc4=%h valid=%b mis=%b expected pc=%h valid=%b mis=%b",
                     n, pc, pc_plus4, valid, misalign, m_pc, m_booted, m_mis);
         end
      end
      clear_redir();
   endtask

   task automatic test_wrap_async_reset();
      ready = 1;
      do_reset();
      cycle();
      checks++;
      if (pc_w !== 32'hFFFF_FFF8 || valid_w !== 1'b1) begin
         failures++;
         $display("FAIL wrap_boot: pc=%h valid=%b expected fffffff8 valid=1", pc_w, valid_w);
      end
      cycle();
      checks++;
      if (pc_w !== 32'hFFFF_FFFC || pc_plus4_w !== 32'h0) begin
         failures++;
         $display("FAIL wrap_last: pc=%h pc4=%h expected fffffffc/00000000", pc_w, pc_plus4_w);
      end
      cycle();
      checks++;
      if (pc_w !== 32'h0) begin
         failures++;
         $display("FAIL wrap_zero: pc=%h expected 00000000", pc_w);
      end
      ready = 0; redir_pc4 = 32'h40; branch_off = 32'h40; branch = 1;
      jr = 1; jr_addr = 32'h0000_0082;
      cycle();
      clear_redir();
      #3;
      rst = 0;
      model_reset();
      #1;
      checks++;
      if (pc_w !== 32'hFFFF_FFF8 || valid_w !== 1'b0 || misalign_w !== 1'b0 ||
          pc !== 32'h0 || valid !== 1'b0 || misalign !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: pc_w=%h valid_w=%b mis_w=%b pc=%h valid=%b mis=%b expected fffffff8/0/0 00000000/0/0",
                  pc_w, valid_w, misalign_w, pc, valid, misalign);
      end
      @(negedge clk);
      rst = 1;
      ready = 1;
      @(posedge clk); #1;
      model_step();
      cycle();
      checks++;
      if (pc_w !== 32'hFFFF_FFFC || pc !== 32'h4 || pc !== m_pc) begin
         failures++;
         $display("FAIL pend_dropped: pc_w=%h pc=%h expected fffffffc/00000004", pc_w, pc);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_branch();
      test_priority();
      test_stall_redirect();
      test_misalign();
      test_random();
      test_wrap_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
